// File: rtl/blind_pkg.sv
// ----------------------------------------------------------------------------
// blind_pkg
//   Shared types and helpers for the multi-channel blind controller.
//   - blind_state_e : per-channel FSM state
//   - cnt_w()       : width of a counter that holds 0..n-1 (never below 1 bit)
//   - *_W_DEF       : counter widths for the default timing parameters
// ----------------------------------------------------------------------------
package blind_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OPENING,
        CLOSING,
        DEAD,
        FAULT
    } blind_state_e;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int STEP_DIV_DEF    = 1000;
    localparam int DEAD_CYC_DEF    = 50;
    localparam int TIMEOUT_CYC_DEF = 200000;

    localparam int STEP_W_DEF = cnt_w(STEP_DIV_DEF);
    localparam int DEAD_W_DEF = cnt_w(DEAD_CYC_DEF);
    localparam int TMO_W_DEF  = cnt_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/blind_ctrl_multi_chan.sv
// ----------------------------------------------------------------------------
// blind_chan_fsm
//   One blind channel: open/close/stop FSM with reversal dead-time, a
//   position estimate, limit-switch handling and a travel timeout.
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     ena                      low: motors off next cycle, everything else frozen
//     cmd_open/close/stop      manual requests (priority stop > close > open)
//     lim_open/lim_closed      end switches, active high
//     auto_open/auto_close     one-cycle injected requests, honoured only in
//                              IDLE and only when no manual command is present
//     mot_up/mot_dn            registered motor drives
//     pos                      registered position estimate, 0 = closed
//     fault                    registered, channel in FAULT
//     busy                     registered, channel in OPENING/CLOSING/DEAD
// ----------------------------------------------------------------------------
module blind_chan_fsm
    import blind_pkg::*;
#(
    parameter int POS_W       = 6,
    parameter int STEP_DIV    = 1000,
    parameter int DEAD_CYC    = 50,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             cmd_open,
    input  logic             cmd_close,
    input  logic             cmd_stop,
    input  logic             lim_open,
    input  logic             lim_closed,
    input  logic             auto_open,
    input  logic             auto_close,
    output logic             mot_up,
    output logic             mot_dn,
    output logic [POS_W-1:0] pos,
    output logic             fault,
    output logic             busy
);

    localparam int STEP_W = cnt_w(STEP_DIV);
    localparam int DEAD_W = cnt_w(DEAD_CYC);
    localparam int TMO_W  = cnt_w(TIMEOUT_CYC);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

    blind_state_e      state_q, state_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DEAD_W-1:0] dead_q, dead_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              dir_up_q, dir_up_d;   // direction taken when DEAD expires
    logic              mot_up_q, mot_up_d;
    logic              mot_dn_q, mot_dn_d;
    logic              fault_q, fault_d;
    logic              busy_q, busy_d;

    logic manual;
    logic eff_open;
    logic eff_close;

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        step_d   = step_q;
        dead_d   = dead_q;
        tmo_d    = tmo_q;
        dir_up_d = dir_up_q;

        // Injected requests only fill in when the channel has no manual command.
        manual    = cmd_open | cmd_close | cmd_stop;
        eff_open  = cmd_open  | (auto_open  & ~manual);
        eff_close = cmd_close | (auto_close & ~manual);

        if (ena) begin
            if (lim_open && lim_closed) begin
                state_d = FAULT;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cmd_stop) begin
                            state_d = IDLE;
                        end else if (eff_close) begin
                            if (!lim_closed) state_d = CLOSING;
                        end else if (eff_open) begin
                            if (!lim_open) state_d = OPENING;
                        end
                    end
                    OPENING: begin
                        if (lim_open) begin
                            state_d = IDLE;
                            pos_d   = '1;
                        end else if (cmd_stop) begin
                            state_d = IDLE;
                        end else if (cmd_close) begin
                            state_d  = DEAD;
                            dir_up_d = 1'b0;
                        end else if (tmo_q == TMO_LAST) begin
                            state_d = FAULT;
                        end
                    end
                    CLOSING: begin
                        if (lim_closed) begin
                            state_d = IDLE;
                            pos_d   = '0;
                        end else if (cmd_stop) begin
                            state_d = IDLE;
                        end else if (cmd_open && !cmd_close) begin
                            state_d  = DEAD;
                            dir_up_d = 1'b1;
                        end else if (tmo_q == TMO_LAST) begin
                            state_d = FAULT;
                        end
                    end
                    DEAD: begin
                        if (cmd_stop) begin
                            state_d = IDLE;
                        end else if (dead_q == DEAD_LAST) begin
                            state_d = dir_up_q ? OPENING : CLOSING;
                        end
                    end
                    FAULT: begin
                        if (cmd_stop && !lim_open && !lim_closed) state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end

            if (state_d != state_q) begin
                step_d = '0;
                dead_d = '0;
                tmo_d  = '0;
            end else if (state_q == OPENING || state_q == CLOSING) begin
                tmo_d = tmo_q + 1'b1;
                // Steps accumulate only while the registered drive is actually on.
                if (mot_up_q || mot_dn_q) begin
                    if (step_q == STEP_LAST) begin
                        step_d = '0;
                        if (state_q == OPENING && pos_q != '1) pos_d = pos_q + 1'b1;
                        if (state_q == CLOSING && pos_q != '0) pos_d = pos_q - 1'b1;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end else if (state_q == DEAD) begin
                dead_d = dead_q + 1'b1;
            end
        end

        mot_up_d = ena && (state_d == OPENING);
        mot_dn_d = ena && (state_d == CLOSING);
        fault_d  = (state_d == FAULT);
        busy_d   = (state_d == OPENING) || (state_d == CLOSING) || (state_d == DEAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pos_q    <= '0;
            step_q   <= '0;
            dead_q   <= '0;
            tmo_q    <= '0;
            dir_up_q <= 1'b0;
            mot_up_q <= 1'b0;
            mot_dn_q <= 1'b0;
            fault_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            step_q   <= step_d;
            dead_q   <= dead_d;
            tmo_q    <= tmo_d;
            dir_up_q <= dir_up_d;
            mot_up_q <= mot_up_d;
            mot_dn_q <= mot_dn_d;
            fault_q  <= fault_d;
            busy_q   <= busy_d;
        end
    end

    assign mot_up = mot_up_q;
    assign mot_dn = mot_dn_q;
    assign pos    = pos_q;
    assign fault  = fault_q;
    assign busy   = busy_q;

endmodule

// File: rtl/blind_ctrl_multi.sv
// ----------------------------------------------------------------------------
// blind_ctrl_multi
//   NCH independent blind channels (blind_chan_fsm) plus the optional
//   ambient-light automation and the global busy flag.
//   Ports:
//     clk, rst_n          clock, async active-low reset
//     ena                 global enable
//     cmd_open/close/stop per-channel requests [NCH]
//     lim_open/closed     per-channel end switches [NCH]
//     light_hi            async light comparator (AUTO_LIGHT_EN builds only)
//     mot_up/mot_dn       per-channel motor drives [NCH]
//     pos                 channel i at [i*POS_W +: POS_W]
//     fault               per-channel FAULT flag [NCH]
//     busy                any channel in OPENING/CLOSING/DEAD
//   Build option: define AUTO_LIGHT_EN to enable light-driven open/close.
// ----------------------------------------------------------------------------
module blind_ctrl_multi
    import blind_pkg::*;
#(
    parameter int NCH         = 2,
    parameter int POS_W       = 6,
    parameter int STEP_DIV    = 1000,
    parameter int DEAD_CYC    = 50,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NCH-1:0]       cmd_open,
    input  logic [NCH-1:0]       cmd_close,
    input  logic [NCH-1:0]       cmd_stop,
    input  logic [NCH-1:0]       lim_open,
    input  logic [NCH-1:0]       lim_closed,
    input  logic                 light_hi,
    output logic [NCH-1:0]       mot_up,
    output logic [NCH-1:0]       mot_dn,
    output logic [NCH*POS_W-1:0] pos,
    output logic [NCH-1:0]       fault,
    output logic                 busy
);

    logic           auto_open;
    logic           auto_close;
    logic [NCH-1:0] busy_ch;

`ifdef AUTO_LIGHT_EN
    // [0],[1] form the synchroniser; [2] holds the previous synchronised value.
    logic [2:0] light_sh_q, light_sh_d;

    always_comb begin
        light_sh_d = {light_sh_q[1:0], light_hi};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) light_sh_q <= '0;
        else        light_sh_q <= light_sh_d;
    end

    assign auto_open  =  light_sh_q[1] & ~light_sh_q[2];
    assign auto_close = ~light_sh_q[1] &  light_sh_q[2];
`else
    logic unused_light;
    assign unused_light = light_hi;
    assign auto_open    = 1'b0;
    assign auto_close   = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        blind_chan_fsm #(
            .POS_W      (POS_W),
            .STEP_DIV   (STEP_DIV),
            .DEAD_CYC   (DEAD_CYC),
            .TIMEOUT_CYC(TIMEOUT_CYC)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena),
            .cmd_open  (cmd_open[i]),
            .cmd_close (cmd_close[i]),
            .cmd_stop  (cmd_stop[i]),
            .lim_open  (lim_open[i]),
            .lim_closed(lim_closed[i]),
            .auto_open (auto_open),
            .auto_close(auto_close),
            .mot_up    (mot_up[i]),
            .mot_dn    (mot_dn[i]),
            .pos       (pos[i*POS_W +: POS_W]),
            .fault     (fault[i]),
            .busy      (busy_ch[i])
        );
    end

    assign busy = |busy_ch;

endmodule

// File: tb/tb_blind_ctrl_multi.sv
// ----------------------------------------------------------------------------
// tb_blind_ctrl_multi
//   Self-checking bench for blind_ctrl_multi (NCH=2, POS_W=4, STEP_DIV=4,
//   DEAD_CYC=3, TIMEOUT_CYC=64). A behavioural model tracks every channel and
//   is compared against all outputs after each clock edge.
// ----------------------------------------------------------------------------
module tb_blind_ctrl_multi;

    localparam int NCH         = 2;
    localparam int POS_W       = 4;
    localparam int STEP_DIV    = 4;
    localparam int DEAD_CYC    = 3;
    localparam int TIMEOUT_CYC = 64;
    localparam int PMAX        = (1 << POS_W) - 1;

    localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_WAIT = 3, M_FAULT = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ena = 1'b1;
    logic [NCH-1:0]       cmd_open = '0, cmd_close = '0, cmd_stop = '0;
    logic [NCH-1:0]       lim_open = '0, lim_closed = '0;
    logic                 light_hi = 1'b0;
    logic [NCH-1:0]       mot_up, mot_dn, fault;
    logic [NCH*POS_W-1:0] pos;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    blind_ctrl_multi #(
        .NCH(NCH), .POS_W(POS_W), .STEP_DIV(STEP_DIV),
        .DEAD_CYC(DEAD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_open(cmd_open), .cmd_close(cmd_close), .cmd_stop(cmd_stop),
        .lim_open(lim_open), .lim_closed(lim_closed), .light_hi(light_hi),
        .mot_up(mot_up), .mot_dn(mot_dn), .pos(pos), .fault(fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int md[NCH], mpos[NCH], mtick[NCH], mtrav[NCH], mwait[NCH], mpend[NCH];
    bit mup[NCH], mdn[NCH];
    bit [2:0] hist;   // light_hi samples at the previous three edges, [0] newest

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            md[c] = M_IDLE; mpos[c] = 0; mtick[c] = 0; mtrav[c] = 0;
            mwait[c] = 0; mpend[c] = M_IDLE; mup[c] = 0; mdn[c] = 0;
        end
        hist = '0;
    endtask

    task automatic model_edge();
        bit rise, fall, drv, st, cl, op, lo, lc, own_lim, rev;
        int nm, dir;
        rise = 0; fall = 0;
`ifdef AUTO_LIGHT_EN
        rise = hist[1] & ~hist[2];
        fall = ~hist[1] & hist[2];
`endif
        hist = {hist[1:0], light_hi};
        for (int c = 0; c < NCH; c++) begin
            if (!ena) begin
                mup[c] = 0; mdn[c] = 0;
                continue;
            end
            drv = mup[c] | mdn[c];
            st = cmd_stop[c]; cl = cmd_close[c]; op = cmd_open[c];
            lo = lim_open[c]; lc = lim_closed[c];
            if (md[c] == M_IDLE && !(st | cl | op)) begin
                op = rise; cl = fall;
            end
            nm  = md[c];
            dir = (md[c] == M_UP) ? 1 : -1;
            own_lim = (md[c] == M_UP) ? lo : lc;
            rev     = (md[c] == M_UP) ? cl : (op && !cl);
            if (lo && lc) nm = M_FAULT;
            else if (md[c] == M_IDLE) begin
                if (st) nm = M_IDLE;
                else if (cl) begin if (!lc) nm = M_DOWN; end
                else if (op) begin if (!lo) nm = M_UP; end
            end else if (md[c] == M_UP || md[c] == M_DOWN) begin
                if (own_lim) begin
                    nm = M_IDLE;
                    mpos[c] = (md[c] == M_UP) ? PMAX : 0;
                end else if (st) nm = M_IDLE;
                else if (rev) begin
                    nm = M_WAIT;
                    mpend[c] = (md[c] == M_UP) ? M_DOWN : M_UP;
                end else if (mtrav[c] + 1 == TIMEOUT_CYC) nm = M_FAULT;
            end else if (md[c] == M_WAIT) begin
                if (st) nm = M_IDLE;
                else if (mwait[c] == 1) nm = mpend[c];
                else mwait[c]--;
            end else begin
                if (st && !lo && !lc) nm = M_IDLE;
            end

            if (nm != md[c]) begin
                mtrav[c] = 0; mtick[c] = 0; mwait[c] = DEAD_CYC;
            end else if (md[c] == M_UP || md[c] == M_DOWN) begin
                mtrav[c]++;
                if (drv) begin
                    mtick[c]++;
                    if (mtick[c] == STEP_DIV) begin
                        mtick[c] = 0;
                        mpos[c] = mpos[c] + dir;
                        if (mpos[c] > PMAX) mpos[c] = PMAX;
                        if (mpos[c] < 0) mpos[c] = 0;
                    end
                end
            end
            md[c]  = nm;
            mup[c] = (nm == M_UP);
            mdn[c] = (nm == M_DOWN);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        bit b;
        b = 0;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("model ch%0d mot_up", c), 32'(mot_up[c]), 32'(mup[c]));
            check($sformatf("model ch%0d mot_dn", c), 32'(mot_dn[c]), 32'(mdn[c]));
            check($sformatf("model ch%0d fault", c), 32'(fault[c]), 32'(md[c] == M_FAULT));
            check($sformatf("model ch%0d pos", c), 32'(pos[c*POS_W +: POS_W]), 32'(mpos[c]));
            if (md[c] == M_UP || md[c] == M_DOWN || md[c] == M_WAIT) b = 1;
        end
        check("model busy", 32'(busy), 32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Both drives on the same channel must never be active together.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ((mot_up & mot_dn) != '0) begin
                errors++;
                $display("FAIL exclusive drive @%0t: mot_up=%b mot_dn=%b, required no overlap",
                         $time, mot_up, mot_dn);
            end
        end
    end

    // ---------------- directed table (channel 0) ----------------
    typedef struct {
        logic       op, cl, st, lo, lc;
        logic       e_up, e_dn;
        logic [3:0] e_pos;
    } vec_t;

    vec_t tbl[22];

    initial begin
        int p;

        //           op cl st lo lc  up dn pos
        tbl[0]  = '{1, 0, 0, 0, 0, 1, 0, 0};   // open -> drive next cycle
        tbl[1]  = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 1};   // first step after 4 cycles
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 2};
        tbl[9]  = '{0, 0, 0, 1, 0, 0, 0, 15};  // open limit -> all-ones
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 15};
        tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 15};  // open again
        tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 15};  // reversal -> dead time
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 15};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 15};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 1, 15};  // closing after 3 dead cycles
        tbl[16] = '{0, 0, 0, 0, 0, 0, 1, 15};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 1, 15};
        tbl[18] = '{0, 0, 0, 0, 0, 0, 1, 15};
        tbl[19] = '{0, 0, 0, 0, 0, 0, 1, 14};
        tbl[20] = '{0, 0, 0, 0, 1, 0, 0, 0};   // closed limit -> 0
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0};

        // ---- reset ----
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset mot_up", 32'(mot_up), 32'd0);
        check("reset mot_dn", 32'(mot_dn), 32'd0);
        check("reset pos", 32'(pos), 32'd0);
        check("reset fault", 32'(fault), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // ---- table: stepping, limits, dead time ----
        for (int i = 0; i < 22; i++) begin
            cmd_open   = {1'b0, tbl[i].op};
            cmd_close  = {1'b0, tbl[i].cl};
            cmd_stop   = {1'b0, tbl[i].st};
            lim_open   = {1'b0, tbl[i].lo};
            lim_closed = {1'b0, tbl[i].lc};
            tick();
            check($sformatf("tbl[%0d] mot_up0", i), 32'(mot_up[0]), 32'(tbl[i].e_up));
            check($sformatf("tbl[%0d] mot_dn0", i), 32'(mot_dn[0]), 32'(tbl[i].e_dn));
            check($sformatf("tbl[%0d] pos0", i), 32'(pos[3:0]), 32'(tbl[i].e_pos));
        end
        cmd_open = '0; cmd_close = '0; cmd_stop = '0; lim_open = '0; lim_closed = '0;

        // ---- stop beats close and open while closing (ch1) ----
        cmd_close = 2'b10; tick();
        check("ch1 closing mot_dn1", 32'(mot_dn[1]), 32'd1);
        check("ch1 closing busy", 32'(busy), 32'd1);
        cmd_close = 2'b10; cmd_open = 2'b10; cmd_stop = 2'b10; tick();
        check("stop wins mot_dn1", 32'(mot_dn[1]), 32'd0);
        check("stop wins mot_up1", 32'(mot_up[1]), 32'd0);
        check("stop wins busy", 32'(busy), 32'd0);
        cmd_open = '0; cmd_close = '0; cmd_stop = '0; tick();

        // ---- travel timeout (ch0) ----
        cmd_open = 2'b01; tick();
        cmd_open = '0;
        repeat (TIMEOUT_CYC - 1) tick();
        check("pre-timeout mot_up0", 32'(mot_up[0]), 32'd1);
        check("pre-timeout fault0", 32'(fault[0]), 32'd0);
        tick();
        check("timeout fault0", 32'(fault[0]), 32'd1);
        check("timeout mot_up0", 32'(mot_up[0]), 32'd0);
        cmd_open = 2'b01; tick();
        check("fault ignores open", 32'(mot_up[0]), 32'd0);
        check("fault holds", 32'(fault[0]), 32'd1);
        cmd_open = '0; cmd_stop = 2'b01; tick();
        check("fault cleared", 32'(fault[0]), 32'd0);
        check("fault cleared busy", 32'(busy), 32'd0);
        cmd_stop = '0; tick();

        // ---- both limits -> fault (ch1 only) ----
        lim_open = 2'b10; lim_closed = 2'b10; tick();
        check("dual limit fault1", 32'(fault[1]), 32'd1);
        check("dual limit fault0", 32'(fault[0]), 32'd0);
        check("dual limit ch0 motors", 32'({mot_up[0], mot_dn[0]}), 32'd0);
        lim_open = '0; lim_closed = '0; cmd_stop = 2'b10; tick();
        check("dual limit cleared", 32'(fault[1]), 32'd0);
        cmd_stop = '0; tick();

        // ---- ena low mid-motion freezes ch0 ----
        cmd_close = 2'b01; tick();
        check("ena test closing", 32'(mot_dn[0]), 32'd1);
        cmd_close = '0;
        repeat (5) tick();
        p = mpos[0];
        ena = 1'b0; tick();
        check("ena low motor off", 32'(mot_dn[0]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            cmd_open = 2'b11; tick();
            check("ena low pos frozen", 32'(pos[3:0]), 32'(p));
            check("ena low still off", 32'(mot_dn[0] | mot_up[0]), 32'd0);
        end
        cmd_open = '0; ena = 1'b1; tick();
        check("ena restored", 32'(mot_dn[0]), 32'd1);
        cmd_stop = 2'b01; tick();
        cmd_stop = '0;

        // ---- reset mid-motion ----
        cmd_open = 2'b01; tick();
        cmd_open = '0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async reset mot_up0", 32'(mot_up[0]), 32'd0);
        check("async reset pos", 32'(pos), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- ambient light automation ----
        light_hi = 1'b1;
        tick();
        check("light +1 motors", 32'(mot_up), 32'd0);
        tick();
        check("light +2 motors", 32'(mot_up), 32'd0);
        tick();
`ifdef AUTO_LIGHT_EN
        check("light +3 both open", 32'(mot_up), 32'(2'b11));
`else
        check("light ignored", 32'(mot_up), 32'd0);
`endif
        cmd_stop = 2'b11; tick();
        light_hi = 1'b0;
        repeat (4) tick();
        check("manual overrides light", 32'(mot_dn | mot_up), 32'd0);
        cmd_stop = '0; tick();

        // ---- randomized against the model ----
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NCH; c++) begin
                cmd_open[c]   = ($urandom_range(15) == 0);
                cmd_close[c]  = ($urandom_range(15) == 0);
                cmd_stop[c]   = ($urandom_range(23) == 0);
                lim_open[c]   = ($urandom_range(39) == 0);
                lim_closed[c] = ($urandom_range(39) == 0);
            end
            ena = ($urandom_range(31) != 0);
            if ($urandom_range(49) == 0) light_hi = ~light_hi;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
